// File: rtl/irq_cond_pkg.sv
// Shared types and constants for the interrupt conditioning unit.
package irq_cond_pkg;

  typedef enum logic {
    IrqLevel = 1'b0,
    IrqEdge  = 1'b1
  } irq_mode_e;

  localparam int MaxIrq       = 32;
  localparam int MinSyncDepth = 2;

  // A single channel still needs a 1-bit ID field.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_cond_if.sv
// Claim handshake between the core and the interrupt conditioning unit.
interface irq_cond_if #(
  parameter int IdW = 4
);
  logic           claim_valid_i;
  logic [IdW-1:0] claim_id_i;
  logic           claim_err_o;

  modport master (output claim_valid_i, output claim_id_i, input claim_err_o);
  modport slave  (input claim_valid_i, input claim_id_i, output claim_err_o);
endinterface

// File: rtl/irq_cond_chan.sv
// One interrupt channel: synchroniser, optional glitch filter (IRQ_COND_GLITCH_FILTER_EN),
// edge detector and sticky pending/overrun state.
module irq_cond_chan
  import irq_cond_pkg::*;
#(
  parameter int SyncDepth  = 2,
  parameter int FiltCycles = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic irq_i,
  input  logic mode_i,
  input  logic invert_i,
  input  logic claim_i,
  output logic pending_o,
  output logic overrun_o
);

  logic [SyncDepth-1:0] sync_q, sync_d;
  logic                 prev_q, prev_d;
  logic                 pending_q, pending_d;
  logic                 overrun_q, overrun_d;
  logic                 filt_s;
  logic                 lvl;
  logic                 edge_det;

  assign sync_d = {sync_q[SyncDepth-2:0], irq_i};

`ifdef IRQ_COND_GLITCH_FILTER_EN
  localparam int CntW = $clog2(FiltCycles + 1);

  logic            filt_q, filt_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // The filtered value only follows the synchronised input after it has
  // disagreed for FiltCycles consecutive cycles; any agreement restarts the count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[SyncDepth-1] != filt_q) begin
      if (cnt_q == CntW'(FiltCycles - 1)) begin
        filt_d = sync_q[SyncDepth-1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_s = filt_q;
`else
  assign filt_s = sync_q[SyncDepth-1];
`endif

  assign lvl      = filt_s ^ invert_i;
  assign edge_det = lvl & ~prev_q;

  // prev tracks lvl in both modes so a level-to-edge switch sees no false edge.
  always_comb begin
    prev_d    = lvl;
    pending_d = pending_q;
    overrun_d = overrun_q & ~claim_i;
    if (mode_i == IrqEdge) begin
      pending_d = edge_det | (pending_q & ~claim_i);
      if (edge_det && pending_q && !claim_i) begin
        overrun_d = 1'b1;
      end
    end else begin
      pending_d = lvl;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending_o = pending_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/irq_cond_unit.sv
// Interrupt conditioning top: per-channel conditioning, claim decode and priority encoder.
// Optional glitch filter enabled by defining IRQ_COND_GLITCH_FILTER_EN.
module irq_cond_unit
  import irq_cond_pkg::*;
#(
  parameter  int NumIrq     = 15,
  parameter  int SyncDepth  = 2,
  parameter  int FiltCycles = 4,
  localparam int IdW        = id_width(NumIrq)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumIrq-1:0] irq_i,
  input  logic [NumIrq-1:0] mode_i,
  input  logic [NumIrq-1:0] invert_i,
  input  logic [NumIrq-1:0] en_i,
  irq_cond_if.slave         claim_if,
  output logic [NumIrq-1:0] irq_o,
  output logic              irq_valid_o,
  output logic [IdW-1:0]    irq_id_o,
  output logic [NumIrq-1:0] overrun_o
);

  logic [NumIrq-1:0] claim_hit;
  logic [NumIrq-1:0] pending;
  logic              claim_in_range;
  logic              claim_err_q, claim_err_d;
  logic [IdW-1:0]    irq_id;

  assign claim_in_range = {1'b0, claim_if.claim_id_i} < (IdW + 1)'(NumIrq);
  assign claim_err_d    = claim_if.claim_valid_i & ~claim_in_range;

  genvar gi;
  generate
    for (gi = 0; gi < NumIrq; gi++) begin : g_chan
      assign claim_hit[gi] = claim_if.claim_valid_i && (claim_if.claim_id_i == IdW'(gi));

      irq_cond_chan #(
        .SyncDepth  (SyncDepth),
        .FiltCycles (FiltCycles)
      ) u_chan (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .irq_i     (irq_i[gi]),
        .mode_i    (mode_i[gi]),
        .invert_i  (invert_i[gi]),
        .claim_i   (claim_hit[gi]),
        .pending_o (pending[gi]),
        .overrun_o (overrun_o[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      claim_err_q <= 1'b0;
    end else begin
      claim_err_q <= claim_err_d;
    end
  end

  assign claim_if.claim_err_o = claim_err_q;

  // Masked channels keep their pending state and reappear when re-enabled.
  assign irq_o       = pending & en_i;
  assign irq_valid_o = |irq_o;

  // Scan downwards so the lowest set index wins.
  always_comb begin
    irq_id = '0;
    for (int i = NumIrq - 1; i >= 0; i--) begin
      if (irq_o[i]) begin
        irq_id = IdW'(i);
      end
    end
  end

  assign irq_id_o = irq_id;

endmodule

// File: tb/tb_irq_cond_unit.sv
// Directed self-checking bench for irq_cond_unit (NumIrq=15, SyncDepth=2).
module tb_irq_cond_unit;

  localparam int NumIrq = 15;
  localparam int IdW    = 4;
`ifdef IRQ_COND_GLITCH_FILTER_EN
  localparam int LAT = 7;
  localparam int PW  = 5;
`else
  localparam int LAT = 3;
  localparam int PW  = 1;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [NumIrq-1:0] irq_i = '0;
  logic [NumIrq-1:0] mode_i = '1;
  logic [NumIrq-1:0] invert_i = '0;
  logic [NumIrq-1:0] en_i = '1;
  logic [NumIrq-1:0] irq_o;
  logic              irq_valid_o;
  logic [IdW-1:0]    irq_id_o;
  logic [NumIrq-1:0] overrun_o;

  int n_cmp = 0;
  int n_err = 0;

  irq_cond_if #(.IdW(IdW)) claim_if ();

  irq_cond_unit #(.NumIrq(NumIrq), .SyncDepth(2), .FiltCycles(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .irq_i       (irq_i),
    .mode_i      (mode_i),
    .invert_i    (invert_i),
    .en_i        (en_i),
    .claim_if    (claim_if),
    .irq_o       (irq_o),
    .irq_valid_o (irq_valid_o),
    .irq_id_o    (irq_id_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic claim(input logic [IdW-1:0] id);
    claim_if.claim_valid_i = 1'b1;
    claim_if.claim_id_i    = id;
    tick(1);
    claim_if.claim_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    tick(2);
    n_cmp++; if (irq_o !== '0) begin n_err++; $display("FAIL rst_irq: got %h want 0", irq_o); end
    n_cmp++; if (irq_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", irq_valid_o); end
    n_cmp++; if (overrun_o !== '0) begin n_err++; $display("FAIL rst_ovr: got %h want 0", overrun_o); end
    n_cmp++; if (claim_if.claim_err_o !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", claim_if.claim_err_o); end
    rst_i = 1'b0;
    tick(3);
    n_cmp++; if (irq_o !== '0 || irq_id_o !== '0) begin n_err++; $display("FAIL post_rst: irq %h id %0d want 0/0", irq_o, irq_id_o); end
    $display("test_reset done");
  endtask

  task automatic test_edge_claim;
    irq_i[5] = 1'b1;
    tick(PW);
    irq_i[5] = 1'b0;
    tick(LAT - 1 - PW);
    n_cmp++; if (irq_o !== '0) begin n_err++; $display("FAIL edge_early: got %h want 0", irq_o); end
    tick(1);
    n_cmp++; if (irq_o !== 15'h0020) begin n_err++; $display("FAIL edge_lat: got %h want 0020", irq_o); end
    n_cmp++; if (irq_id_o !== 4'd5 || irq_valid_o !== 1'b1) begin n_err++; $display("FAIL edge_id: id %0d valid %b want 5/1", irq_id_o, irq_valid_o); end
    tick(4);
    n_cmp++; if (irq_o !== 15'h0020) begin n_err++; $display("FAIL edge_hold: got %h want 0020", irq_o); end
    claim(4'd5);
    n_cmp++; if (irq_o !== '0 || irq_valid_o !== 1'b0) begin n_err++; $display("FAIL edge_claim: irq %h valid %b want 0/0", irq_o, irq_valid_o); end
    $display("test_edge_claim done");
  endtask

  task automatic test_priority_overrun;
    irq_i = 15'h0208;
    tick(PW);
    irq_i = '0;
    tick(LAT - PW);
    n_cmp++; if (irq_o !== 15'h0208 || irq_id_o !== 4'd3) begin n_err++; $display("FAIL prio_both: irq %h id %0d want 0208/3", irq_o, irq_id_o); end
    claim(4'd3);
    n_cmp++; if (irq_o !== 15'h0200 || irq_id_o !== 4'd9) begin n_err++; $display("FAIL prio_after3: irq %h id %0d want 0200/9", irq_o, irq_id_o); end
    tick(LAT);
    irq_i[9] = 1'b1;
    tick(PW);
    irq_i[9] = 1'b0;
    tick(LAT - PW);
    n_cmp++; if (overrun_o !== 15'h0200 || irq_o !== 15'h0200) begin n_err++; $display("FAIL ovr_set: ovr %h irq %h want 0200/0200", overrun_o, irq_o); end
    claim(4'd9);
    n_cmp++; if (overrun_o !== '0 || irq_o !== '0) begin n_err++; $display("FAIL ovr_claim: ovr %h irq %h want 0/0", overrun_o, irq_o); end
    tick(LAT);
    irq_i[9] = 1'b1;
    tick(PW);
    irq_i[9] = 1'b0;
    tick(LAT - PW);
    tick(LAT);
    irq_i[9] = 1'b1;
    tick(PW);
    irq_i[9] = 1'b0;
    tick(LAT - PW - 1);
    claim(4'd9);
    n_cmp++; if (irq_o !== 15'h0200 || overrun_o !== '0) begin n_err++; $display("FAIL collide: irq %h ovr %h want 0200/0", irq_o, overrun_o); end
    claim(4'd9);
    n_cmp++; if (irq_o !== '0) begin n_err++; $display("FAIL collide_clr: got %h want 0", irq_o); end
    $display("test_priority_overrun done");
  endtask

  task automatic test_mask_badclaim;
    en_i[7] = 1'b0;
    irq_i[7] = 1'b1;
    tick(PW);
    irq_i[7] = 1'b0;
    tick(LAT - PW + 2);
    n_cmp++; if (irq_o !== '0 || irq_valid_o !== 1'b0) begin n_err++; $display("FAIL mask_hide: irq %h valid %b want 0/0", irq_o, irq_valid_o); end
    en_i[7] = 1'b1;
    #1;
    n_cmp++; if (irq_o !== 15'h0080 || irq_id_o !== 4'd7) begin n_err++; $display("FAIL mask_show: irq %h id %0d want 0080/7", irq_o, irq_id_o); end
    claim(4'd15);
    n_cmp++; if (claim_if.claim_err_o !== 1'b1) begin n_err++; $display("FAIL bad_err: got %b want 1", claim_if.claim_err_o); end
    n_cmp++; if (irq_o !== 15'h0080 || overrun_o !== '0) begin n_err++; $display("FAIL bad_state: irq %h ovr %h want 0080/0", irq_o, overrun_o); end
    tick(1);
    n_cmp++; if (claim_if.claim_err_o !== 1'b0) begin n_err++; $display("FAIL bad_pulse: got %b want 0", claim_if.claim_err_o); end
    claim(4'd7);
    n_cmp++; if (irq_o !== '0 || claim_if.claim_err_o !== 1'b0) begin n_err++; $display("FAIL good_claim: irq %h err %b want 0/0", irq_o, claim_if.claim_err_o); end
    $display("test_mask_badclaim done");
  endtask

  task automatic test_level_invert;
    mode_i[2] = 1'b0;
    invert_i[2] = 1'b1;
    irq_i[2] = 1'b1;
    tick(LAT + 4);
    n_cmp++; if (irq_o !== '0) begin n_err++; $display("FAIL lvl_idle: got %h want 0", irq_o); end
    irq_i[2] = 1'b0;
    tick(LAT - 1);
    n_cmp++; if (irq_o !== '0) begin n_err++; $display("FAIL lvl_early: got %h want 0", irq_o); end
    tick(1);
    n_cmp++; if (irq_o !== 15'h0004) begin n_err++; $display("FAIL lvl_rise: got %h want 0004", irq_o); end
    claim(4'd2);
    n_cmp++; if (irq_o !== 15'h0004) begin n_err++; $display("FAIL lvl_claim: got %h want 0004", irq_o); end
    irq_i[2] = 1'b1;
    tick(LAT - 1);
    n_cmp++; if (irq_o !== 15'h0004) begin n_err++; $display("FAIL lvl_hold: got %h want 0004", irq_o); end
    tick(1);
    n_cmp++; if (irq_o !== '0) begin n_err++; $display("FAIL lvl_fall: got %h want 0", irq_o); end
    mode_i[2] = 1'b1;
    invert_i[2] = 1'b0;
    irq_i[2] = 1'b0;
    tick(LAT + 4);
    claim(4'd2);
    n_cmp++; if (irq_o !== '0 || overrun_o !== '0) begin n_err++; $display("FAIL lvl_restore: irq %h ovr %h want 0/0", irq_o, overrun_o); end
    $display("test_level_invert done");
  endtask

  task automatic test_reset_mid;
    irq_i = 15'h0208;
    tick(PW);
    irq_i = '0;
    tick(LAT);
    irq_i[9] = 1'b1;
    tick(PW);
    irq_i[9] = 1'b0;
    tick(LAT);
    n_cmp++; if (irq_o !== 15'h0208 || overrun_o !== 15'h0200) begin n_err++; $display("FAIL mid_pre: irq %h ovr %h want 0208/0200", irq_o, overrun_o); end
    #2;
    rst_i = 1'b1;
    #1;
    n_cmp++; if (irq_o !== '0 || irq_valid_o !== 1'b0 || irq_id_o !== '0) begin n_err++; $display("FAIL mid_async: irq %h valid %b id %0d want 0", irq_o, irq_valid_o, irq_id_o); end
    n_cmp++; if (overrun_o !== '0) begin n_err++; $display("FAIL mid_ovr: got %h want 0", overrun_o); end
    tick(2);
    rst_i = 1'b0;
    tick(LAT + 3);
    n_cmp++; if (irq_o !== '0 || overrun_o !== '0) begin n_err++; $display("FAIL mid_after: irq %h ovr %h want 0/0", irq_o, overrun_o); end
    $display("test_reset_mid done");
  endtask

`ifdef IRQ_COND_GLITCH_FILTER_EN
  task automatic test_glitch;
    irq_i[0] = 1'b1;
    tick(3);
    irq_i[0] = 1'b0;
    tick(10);
    n_cmp++; if (irq_o !== '0) begin n_err++; $display("FAIL glitch_drop: got %h want 0", irq_o); end
    irq_i[0] = 1'b1;
    tick(6);
    irq_i[0] = 1'b0;
    n_cmp++; if (irq_o !== '0) begin n_err++; $display("FAIL glitch_early: got %h want 0", irq_o); end
    tick(1);
    n_cmp++; if (irq_o !== 15'h0001) begin n_err++; $display("FAIL glitch_pass: got %h want 0001", irq_o); end
    claim(4'd0);
    $display("test_glitch done");
  endtask
`endif

  initial begin
    claim_if.claim_valid_i = 1'b0;
    claim_if.claim_id_i    = '0;
    test_reset();
    test_edge_claim();
    test_priority_overrun();
    test_mask_badclaim();
    test_level_invert();
    test_reset_mid();
`ifdef IRQ_COND_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/irq_cond_unit.md
Name: irq_cond_unit

Overview:
- Parametrised interrupt conditioning block between SoC interrupt sources and the core's fast-IRQ inputs.
- Supersedes the fixed 15-line, depth-2 per-line synchroniser in the core wrapper.
- Adds per-channel edge/level mode, polarity, enable mask, sticky pending with claim handshake, overrun detection and a priority-encoded ID.
- Instantiated inside the core wrapper. Output `irq_o` drives the core's `irq_fast_i` directly.

Parameters:
- NumIrq, 15, number of interrupt channels (1..32).
- SyncDepth, 2, synchroniser flop stages per channel (>=2).
- FiltCycles, 4, stability window in cycles for the optional glitch filter (>=1).
- IdW, $clog2(NumIrq) (min 1), width of ID fields. Derived; do not override.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, asynchronous reset, active-high.
- irq_i, in, NumIrq, raw asynchronous interrupt sources.
- mode_i, in, NumIrq, per channel: 1 = edge, 0 = level. Quasi-static.
- invert_i, in, NumIrq, per channel: 1 = active-low source.
- en_i, in, NumIrq, per-channel enable mask.
- claim_valid_i, in, 1, one-cycle claim strobe.
- claim_id_i, in, IdW, channel being claimed.
- claim_err_o, out, 1, pulse: claim ID out of range.
- irq_o, out, NumIrq, conditioned interrupts to the core.
- irq_valid_o, out, 1, at least one enabled pending channel.
- irq_id_o, out, IdW, lowest-index enabled pending channel.
- overrun_o, out, NumIrq, sticky: edge lost while already pending.

Behaviour:
- Reset: all synchroniser, filter, previous-value, pending and overrun flops cleared. All outputs are 0 during and after reset until new input activity.
- Sync stage: irq_i[i] passes through SyncDepth flops (tech_sync) to give s[i]. Then lvl[i] = filt(s[i]) ^ invert_i[i].
- prev[i] registers lvl[i] every cycle, in both modes.
- Edge mode:
  - edge = lvl & ~prev.
  - Pending is set on edge and cleared by a claim of i.
  - Edge and claim of i in the same cycle: set wins, pending stays 1.
  - Edge while pending is already 1 and not claimed that cycle: overrun[i] <= 1.
- Level mode: pending[i] <= lvl[i] every cycle. Claims do not clear pending. Overrun is never set.
- Latency: an input transition stable before a clock edge reaches irq_o exactly SyncDepth+1 cycles later (filter disabled).
- Outputs:
  - irq_o = pending & en_i, combinational from flops.
  - irq_valid_o = |irq_o.
  - irq_id_o = index of the lowest set bit of irq_o, or 0 when none is set.
- Claim handshake:
  - A claim is accepted on any cycle with claim_valid_i high; there is no ready.
  - A valid claim clears pending (edge mode only) and overrun[claim_id_i] on the next edge.
  - If claim_id_i >= NumIrq: no state change, and claim_err_o pulses high for one cycle on the following cycle (registered).
- Disabled channels: a pending bit still sets and holds while en_i is low. It appears on irq_o when re-enabled.
- Mode switch:
  - Edge to level: pending reloads from lvl next cycle.
  - Level to edge: no spurious edge, because prev is continuously tracked.
- Invert toggle: this can create one edge in edge mode. That is intended and documented.

Optional Feature:
- Macro: IRQ_COND_GLITCH_FILTER_EN.
- Defined: per-channel counter, width $clog2(FiltCycles+1).
  - filt(s) updates to s only after s differs from the current filtered value for FiltCycles consecutive cycles.
  - Any reversion resets the counter to 0.
  - Added latency is exactly FiltCycles. Pulses shorter than FiltCycles are dropped.
  - Filtered value and counter reset to 0.
- Undefined: filt(s) = s, FiltCycles is ignored, and no counters are synthesised.

Decomposition:
- Package irq_cond_pkg:
  - typedef irq_mode_e {IrqLevel = 1'b0, IrqEdge = 1'b1}.
  - Constants MaxIrq = 32 and MinSyncDepth = 2.
- Sub-module irq_cond_chan, generated NumIrq times. It contains sync, optional filter, prev, and pending/overrun update logic.
- The top holds the claim decode, claim_err register and priority encoder.

Test Plan:
- Edge capture and claim:
  - Stimulus: NumIrq=15, SyncDepth=2, mode_i=all edge, en_i=all 1. Pulse irq_i[5] high for 1 cycle.
  - Response: irq_o[5]=1 exactly 3 cycles later, irq_id_o=5, irq_valid_o=1. Held until claim_id_i=5, then irq_o=0 next cycle.
- Priority, overrun and claim collision:
  - Stimulus: edges on channels 3 and 9.
  - Response: irq_id_o=3. After claiming 3, irq_id_o=9.
  - Stimulus: second edge on 9 while still pending.
  - Response: overrun_o[9]=1. Claim 9 clears both pending[9] and overrun_o[9].
  - Stimulus: edge on 9 coincides with claim 9.
  - Response: pending[9] stays 1.
- Level mode with inversion:
  - Stimulus: mode_i[2]=0, invert_i[2]=1. Drive irq_i[2]=0.
  - Response: irq_o[2]=1 after 3 cycles. Claim 2 has no effect. irq_i[2]=1 gives irq_o[2]=0 after 3 cycles.
- Mask and bad claim:
  - Stimulus: en_i[7]=0, then edge on 7.
  - Response: irq_o[7]=0. Set en_i[7]=1 and irq_o[7]=1 the same cycle.
  - Stimulus: claim_id_i=15.
  - Response: claim_err_o=1 for one cycle and no state change.
- Reset mid-operation: with several channels pending and overrun set, assert rst_i asynchronously. All outputs go to 0 immediately. After release, no IRQ appears without new edges.
- Glitch filter (IRQ_COND_GLITCH_FILTER_EN, FiltCycles=4):
  - Stimulus: 3-cycle pulse on irq_i[0].
  - Response: no pending.
  - Stimulus: 6-cycle pulse on irq_i[0].
  - Response: irq_o[0]=1 exactly 7 cycles after the rising edge.
